// File: rtl/hp_pkg.sv
// Shared types and AXI constants for the HP burst sequencer.
// Used by hp_outstanding_ctr and hp_burst_sequencer.
package hp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam int         BEATS_PER_BURST = 256;
  localparam int         BURST_BYTES     = 4096;
  localparam logic [2:0] AXI_SIZE_16B    = 3'd4;

  // AXI len is beats-1; the final beat index of a burst has the same value.
  localparam logic [7:0] AXI_LEN_LAST    = 8'(BEATS_PER_BURST - 1);
  localparam int         BURST_SHIFT     = $clog2(BURST_BYTES);

endpackage

// File: rtl/hp_outstanding_ctr.sv
// Up/down counter of bursts issued but not yet completed.
// Simultaneous inc and dec leave the count unchanged; full flags the issue limit.
module hp_outstanding_ctr
  import hp_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  localparam int CW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clr,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          full
);

  // Track bursts in flight; a new sequence starts from zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !dec) begin
      count <= count + CW'(1);
    end else if (dec && !inc) begin
      count <= count - CW'(1);
    end
  end

  assign full = (count == CW'(MAX_OUTSTANDING));

endmodule

// File: rtl/hp_burst_sequencer.sv
// Issues 4KB INCR bursts over an address range on the HP AXI master port,
// either writing kernel beats or returning read beats to the kernel.
// Optional build macro: HP_BURST_SEQ_PERF_EN enables the busy-cycle counter.
module hp_burst_sequencer
  import hp_pkg::*;
#(
  parameter int HP_ADDR_WIDTH   = 48,
  parameter int HP_DATA_WIDTH   = 128,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       start,
  input  logic                       clear,
  input  logic                       mode,
  input  logic [HP_ADDR_WIDTH-1:0]   start_addr,
  input  logic [HP_ADDR_WIDTH-1:0]   end_addr,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  input  logic [HP_DATA_WIDTH-1:0]   wd_data,
  input  logic                       wd_valid,
  output logic                       wd_ready,
  output logic [HP_DATA_WIDTH-1:0]   rd_data,
  output logic                       rd_valid,
  output logic [31:0]                perf_cycles,
  output logic [HP_ADDR_WIDTH-1:0]   hp_awaddr,
  output logic [7:0]                 hp_awlen,
  output logic [2:0]                 hp_awsize,
  output logic [1:0]                 hp_awburst,
  output logic                       hp_awvalid,
  input  logic                       hp_awready,
  output logic [HP_DATA_WIDTH-1:0]   hp_wdata,
  output logic [HP_DATA_WIDTH/8-1:0] hp_wstrb,
  output logic                       hp_wlast,
  output logic                       hp_wvalid,
  input  logic                       hp_wready,
  input  logic [1:0]                 hp_bresp,
  input  logic                       hp_bvalid,
  output logic                       hp_bready,
  output logic [HP_ADDR_WIDTH-1:0]   hp_araddr,
  output logic [7:0]                 hp_arlen,
  output logic [2:0]                 hp_arsize,
  output logic [1:0]                 hp_arburst,
  output logic                       hp_arvalid,
  input  logic                       hp_arready,
  input  logic [HP_DATA_WIDTH-1:0]   hp_rdata,
  input  logic [1:0]                 hp_rresp,
  input  logic                       hp_rlast,
  input  logic                       hp_rvalid,
  output logic                       hp_rready
);

  localparam int AW  = HP_ADDR_WIDTH;
  localparam int NBW = HP_ADDR_WIDTH - BURST_SHIFT;
  localparam int CW  = $clog2(MAX_OUTSTANDING + 1);

  seq_state_t     state_q, state_nxt;
  logic           mode_q;
  logic [AW-1:0]  addr_q;
  logic [NBW-1:0] left_q;
  logic [CW-1:0]  wcred_q;
  logic [7:0]     beat_q;
  logic           err_q;

  logic [NBW-1:0] nburst;
  logic           empty_rng, start_ok, issue_ok, w_ok;
  logic           aw_hs, ar_hs, a_hs, w_hs, wlast_hs, b_hs, r_hs, rl_hs;
  logic [CW-1:0]  ost_cnt;
  logic           ost_full, ost_dec, drain_fin, wcred_fin;

  assign busy = (state_q == RUN) || (state_q == DRAIN);
  assign done = (state_q == DONE);
  assign err  = err_q;

  // Burst count from the 4KB-aligned range; a zero-burst range completes at once.
  assign nburst    = end_addr[AW-1:BURST_SHIFT] - start_addr[AW-1:BURST_SHIFT];
  assign empty_rng = (end_addr <= start_addr) || (nburst == '0);
  assign start_ok  = start && ((state_q == IDLE) || (state_q == DONE));

  // Address channels: only the one matching the latched mode is ever driven.
  assign issue_ok   = (state_q == RUN) && (left_q != '0) && !ost_full;
  assign hp_awvalid = issue_ok && !mode_q;
  assign hp_arvalid = issue_ok && mode_q;
  assign hp_awaddr  = addr_q;
  assign hp_araddr  = addr_q;
  assign hp_awlen   = AXI_LEN_LAST;
  assign hp_arlen   = AXI_LEN_LAST;
  assign hp_awsize  = AXI_SIZE_16B;
  assign hp_arsize  = AXI_SIZE_16B;
  assign hp_awburst = AXI_BURST_INCR;
  assign hp_arburst = AXI_BURST_INCR;

  // W beats flow only against an accepted AW whose data is not yet fully sent.
  assign w_ok      = (wcred_q != '0);
  assign hp_wvalid = wd_valid && w_ok;
  assign wd_ready  = hp_wready && w_ok;
  assign hp_wdata  = wd_data;
  assign hp_wstrb  = '1;
  assign hp_wlast  = (beat_q == AXI_LEN_LAST);

  assign hp_bready = busy;
  assign hp_rready = busy;
  assign rd_data   = hp_rdata;
  assign rd_valid  = hp_rvalid && busy;

  assign aw_hs    = hp_awvalid && hp_awready;
  assign ar_hs    = hp_arvalid && hp_arready;
  assign a_hs     = aw_hs || ar_hs;
  assign w_hs     = hp_wvalid && hp_wready;
  assign wlast_hs = w_hs && hp_wlast;
  assign b_hs     = hp_bvalid && hp_bready;
  assign r_hs     = hp_rvalid && hp_rready;
  assign rl_hs    = r_hs && hp_rlast;
  assign ost_dec  = mode_q ? rl_hs : b_hs;

  hp_outstanding_ctr #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_ost (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (start_ok),
    .inc   (a_hs),
    .dec   (ost_dec),
    .count (ost_cnt),
    .full  (ost_full)
  );

  // Drain finishes when the counts reach zero after this edge, so done rises
  // the cycle after the final response handshake.
  assign wcred_fin = (wcred_q == '0) || ((wcred_q == CW'(1)) && wlast_hs);
  assign drain_fin = ((ost_cnt == '0) || ((ost_cnt == CW'(1)) && ost_dec)) &&
                     (mode_q || wcred_fin);

  // Sequence state transitions.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_nxt = empty_rng ? DONE : RUN;
      RUN:     if (a_hs && (left_q == NBW'(1))) state_nxt = DRAIN;
      DRAIN:   if (drain_fin) state_nxt = DONE;
      DONE: begin
        if (start_ok)   state_nxt = empty_rng ? DONE : RUN;
        else if (clear) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_nxt;
  end

  // Sequence context: latched at start, address advances per accepted burst.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode_q <= 1'b0;
      addr_q <= '0;
      left_q <= '0;
    end else if (start_ok) begin
      mode_q <= mode;
      addr_q <= start_addr;
      left_q <= empty_rng ? '0 : nburst;
    end else if (a_hs) begin
      addr_q <= addr_q + AW'(BURST_BYTES);
      left_q <= left_q - NBW'(1);
    end
  end

  // W bookkeeping: credits of AW-accepted bursts and the beat index within a burst.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wcred_q <= '0;
      beat_q  <= '0;
    end else if (start_ok) begin
      wcred_q <= '0;
      beat_q  <= '0;
    end else begin
      if (aw_hs && !wlast_hs)      wcred_q <= wcred_q + CW'(1);
      else if (wlast_hs && !aw_hs) wcred_q <= wcred_q - CW'(1);
      if (w_hs) beat_q <= beat_q + 8'd1;
    end
  end

  // Sticky error on any non-OKAY response within the current sequence.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_q <= 1'b0;
    end else if (start_ok || (done && clear)) begin
      err_q <= 1'b0;
    end else if ((b_hs && (hp_bresp != 2'b00)) || (r_hs && (hp_rresp != 2'b00))) begin
      err_q <= 1'b1;
    end
  end

`ifdef HP_BURST_SEQ_PERF_EN
  logic [31:0] perf_q;

  // Busy-cycle counter: restarts with each sequence, saturates, holds once done.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_q <= '0;
    end else if (start_ok) begin
      perf_q <= '0;
    end else if (busy && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = '0;
`endif

endmodule
